// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the data-cache responder.
// FSM state enum, request-tag fields, READ/WRITE values, address-width helpers.
package dcache_pkg;

  localparam int SETS_DEF       = 64;
  localparam int LINE_WORDS_DEF = 8;
  localparam int TAG_W_DEF      = 13;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 0;

  localparam logic TAG_READ  = 1'b1;
  localparam logic TAG_WRITE = 1'b0;

  // Byte offset inside one 64-bit word.
  localparam int OFF_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL_REQ,
    FILL_DATA,
    RESPOND
  } state_e;

  function automatic int read_bit(input int tag_w);
    return tag_w - 1;
  endfunction

  function automatic int word_w(input int lw);
    return $clog2(lw);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int ltag_w(input int sets, input int lw);
    return 64 - OFF_W - $clog2(lw) - $clog2(sets);
  endfunction

endpackage

// File: rtl/dcache_core_responder_if.sv
// dcache_core_responder_if: request/response bus between initiator and responder.
// Ports: reqcyc/req/reqtag/respack from master; reqack/respcyc/resp from slave.
interface dcache_core_responder_if #(
  parameter int TAG_W = 13
);

  logic             reqcyc;
  logic [63:0]      req;
  logic [TAG_W-1:0] reqtag;
  logic             reqack;
  logic             respcyc;
  logic [63:0]      resp;
  logic             respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp
  );

endinterface

// File: rtl/dcache_line_store.sv
// dcache_line_store: direct-mapped valid/tag/data arrays for the responder.
// Ports: clk, reset, async read (rd_idx/rd_word), one write port, tag set/invalidate.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int SETS       = SETS_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int LTAG_W     = ltag_w(SETS, LINE_WORDS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(SETS)-1:0]       rd_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
  output logic                          rd_valid,
  output logic [LTAG_W-1:0]             rd_tag,
  output logic [63:0]                   rd_data,
  input  logic                          wr_en,
  input  logic [$clog2(SETS)-1:0]       wr_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
  input  logic [63:0]                   wr_data,
  input  logic                          tag_en,
  input  logic                          inv_en,
  input  logic [LTAG_W-1:0]             wr_tag
);

  logic [SETS-1:0]   valid;
  logic [LTAG_W-1:0] tags [SETS];
  logic [63:0]       data [SETS*LINE_WORDS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (tag_en) begin
      valid[wr_idx] <= 1'b1;
    end else if (inv_en) begin
      valid[wr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_en) begin
      tags[wr_idx] <= wr_tag;
    end
    if (wr_en) begin
      data[{wr_idx, wr_word}] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[{rd_idx, rd_word}];

endmodule

// File: rtl/dcache_core_responder.sv
// dcache_core_responder: serves core loads from a direct-mapped line store, fills
// misses over the mem port. Ports: clk, reset, core (slave), mem (master), stats.
// Macro DCACHE_STATS_EN enables saturating hit_count/miss_count; else both are 0.
module dcache_core_responder
  import dcache_pkg::*;
#(
  parameter int SETS       = SETS_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int TAG_W      = TAG_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  dcache_core_responder_if.slave         core,
  dcache_core_responder_if.master        mem,
  output logic [31:0]                    hit_count,
  output logic [31:0]                    miss_count
);

  localparam int WW       = word_w(LINE_WORDS);
  localparam int IW       = idx_w(SETS);
  localparam int LT_W     = ltag_w(SETS, LINE_WORDS);
  localparam int RB       = read_bit(TAG_W);
  localparam int LINE_LSB = OFF_W + WW;
  localparam int TAG_LSB  = LINE_LSB + IW;

  state_e           state;
  logic [63:0]      addr;
  logic [TAG_W-1:0] rtag;
  logic [WW-1:0]    beat_cnt;

  logic [IW-1:0]    idx;
  logic [WW-1:0]    word;
  logic [LT_W-1:0]  ltag;
  logic             is_read;
  logic             rd_valid;
  logic [LT_W-1:0]  rd_tag;
  logic [63:0]      rd_data;
  logic             hit;
  logic             beat;
  logic             last;
  logic             inv;
  logic             unused;

  assign idx     = addr[LINE_LSB +: IW];
  assign word    = addr[OFF_W +: WW];
  assign ltag    = addr[63:TAG_LSB];
  assign is_read = rtag[RB] == TAG_READ;
  assign hit     = rd_valid && (rd_tag == ltag);
  assign beat    = (state == FILL_DATA) && mem.respcyc;
  assign last    = beat && (beat_cnt == WW'(LINE_WORDS - 1));
  // A write tag drops the line only if its tag matches; data is untouched.
  assign inv     = (state == LOOKUP) && !is_read && (rd_tag == ltag);
  assign unused  = ^addr[OFF_W-1:0];

  dcache_line_store #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .LTAG_W     (LT_W)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx),
    .rd_word  (word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (beat),
    .wr_idx   (idx),
    .wr_word  (beat_cnt),
    .wr_data  (mem.resp),
    .tag_en   (last),
    .inv_en   (inv),
    .wr_tag   (ltag)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      rtag         <= '0;
      beat_cnt     <= '0;
      core.reqack  <= 1'b0;
      core.respcyc <= 1'b0;
      core.resp    <= '0;
      mem.reqcyc   <= 1'b0;
      mem.req      <= '0;
      mem.reqtag   <= '0;
      mem.respack  <= 1'b0;
    end else begin
      core.reqack <= 1'b0;
      mem.respack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (core.reqcyc) begin
            addr        <= core.req;
            rtag        <= core.reqtag;
            core.reqack <= 1'b1;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!is_read) begin
            core.resp    <= '0;
            core.respcyc <= 1'b1;
            state        <= RESPOND;
          end else if (hit) begin
            core.resp    <= rd_data;
            core.respcyc <= 1'b1;
            state        <= RESPOND;
          end else begin
            mem.reqcyc <= 1'b1;
            mem.req    <= {addr[63:LINE_LSB], {LINE_LSB{1'b0}}};
            mem.reqtag <= rtag;
            state      <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (mem.reqack) begin
            mem.reqcyc <= 1'b0;
            beat_cnt   <= '0;
            state      <= FILL_DATA;
          end
        end
        FILL_DATA: begin
          if (mem.respcyc) begin
            // Critical word is captured as it streams past.
            if (beat_cnt == word) begin
              core.resp <= mem.resp;
            end
            if (last) begin
              beat_cnt     <= '0;
              mem.respack  <= 1'b1;
              core.respcyc <= 1'b1;
              state        <= RESPOND;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RESPOND: begin
          if (core.respack) begin
            core.respcyc <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic lookup_rd;
  assign lookup_rd = (state == LOOKUP) && is_read;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (lookup_rd) begin
      if (hit && (hit_count != '1)) begin
        hit_count <= hit_count + 1'b1;
      end
      if (!hit && (miss_count != '1)) begin
        miss_count <= miss_count + 1'b1;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_core_responder.sv
// tb_dcache_core_responder: directed bench with a transaction-level cache model.
// Drives core and mem sides, checks outputs each cycle against the model.
module tb_dcache_core_responder;

  localparam int SETS   = 64;
  localparam int LW     = 8;
  localparam int TW     = 13;
  localparam int LINE_B = LW * 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  dcache_core_responder_if #(.TAG_W(TW)) core_if ();
  dcache_core_responder_if #(.TAG_W(TW)) mem_if ();

  dcache_core_responder #(
    .SETS       (SETS),
    .LINE_WORDS (LW),
    .TAG_W      (TW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .core       (core_if),
    .mem        (mem_if),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int checks = 0;
  int errors = 0;

  bit          mv [SETS];
  logic [63:0] mt [SETS];
  int          m_hits = 0;
  int          m_misses = 0;
  logic [63:0] exp_resp = '0;
  logic [63:0] exp_line = '0;
  logic [TW-1:0] exp_tag = '0;
  bit          exp_fill = 1'b0;
  bit          exp_hit = 1'b0;
  logic [63:0] last_resp = '0;

  int ack_delay = 0;
  int beat_idx = -1;
  int stray_req = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero();
    chk("rst_reqack", 64'(core_if.reqack), 64'd0);
    chk("rst_respcyc", 64'(core_if.respcyc), 64'd0);
    chk("rst_resp", core_if.resp, 64'd0);
    chk("rst_mreqcyc", 64'(mem_if.reqcyc), 64'd0);
    chk("rst_mreq", mem_if.req, 64'd0);
    chk("rst_mreqtag", 64'(mem_if.reqtag), 64'd0);
    chk("rst_mrespack", 64'(mem_if.respack), 64'd0);
    chk("rst_hits", 64'(hit_count), 64'd0);
    chk("rst_misses", 64'(miss_count), 64'd0);
  endtask

  // Backing memory: word w of line L holds 0x11 + w + (L - 0x40) * 0x100.
  function automatic logic [63:0] mem_word(input logic [63:0] line,
                                           input int w);
    return 64'h11 + 64'(w) + (line - 64'h40) * 64'h100;
  endfunction

  function automatic logic [TW-1:0] mk_tag(input bit rd);
    return rd ? {1'b1, 4'b0, 8'h5A} : {1'b0, 4'b0, 8'hA5};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
    exp_fill = 1'b0;
  endtask

  task automatic model_apply(input logic [63:0] a, input bit rd);
    logic [63:0] line;
    logic [63:0] t;
    int set;
    int w;
    line = a / LINE_B;
    set = int'(line % SETS);
    t = line / SETS;
    w = int'((a / 8) % LW);
    exp_tag = mk_tag(rd);
    exp_line = line * LINE_B;
    exp_fill = 1'b0;
    exp_hit = 1'b0;
    if (rd) begin
      exp_resp = mem_word(line, w);
      if (mv[set] && mt[set] == t) begin
        exp_hit = 1'b1;
        m_hits++;
      end else begin
        exp_fill = 1'b1;
        m_misses++;
        mv[set] = 1'b1;
        mt[set] = t;
      end
    end else begin
      exp_resp = '0;
      if (mv[set] && mt[set] == t) mv[set] = 1'b0;
    end
  endtask

  // Per-cycle comparison against the model.
  logic [63:0] prev_resp = '0;
  bit          prev_v = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      chk_zero();
      prev_v = 1'b0;
    end else begin
      if (core_if.respcyc) begin
        chk("resp_data", core_if.resp, exp_resp);
        if (prev_v) chk("resp_stable", core_if.resp, prev_resp);
`ifdef DCACHE_STATS_EN
        chk("hit_count", 64'(hit_count), 64'(m_hits));
        chk("miss_count", 64'(miss_count), 64'(m_misses));
`else
        chk("hit_count", 64'(hit_count), 64'd0);
        chk("miss_count", 64'(miss_count), 64'd0);
`endif
      end
      if (mem_if.reqcyc) begin
        chk("mem_req", mem_if.req, exp_line);
        chk("mem_reqtag", 64'(mem_if.reqtag), 64'(exp_tag));
      end
      if (!exp_fill) chk("no_fill", 64'(mem_if.reqcyc), 64'd0);
      prev_v = core_if.respcyc;
      prev_resp = core_if.resp;
    end
  end

  // Memory-side initiator model.
  initial begin
    logic [63:0] line;
    bit aborted;
    int stray_done;
    stray_done = 0;
    mem_if.reqack = 1'b0;
    mem_if.respcyc = 1'b0;
    mem_if.resp = '0;
    forever begin
      @(negedge clk);
      if (!reset && mem_if.reqcyc) begin
        repeat (ack_delay) @(negedge clk);
        mem_if.reqack = 1'b1;
        line = mem_if.req / LINE_B;
        @(negedge clk);
        mem_if.reqack = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i < LW; i++) begin
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          beat_idx = i;
          mem_if.respcyc = 1'b1;
          mem_if.resp = mem_word(line, i);
          @(negedge clk);
        end
        mem_if.respcyc = 1'b0;
        mem_if.resp = '0;
        beat_idx = -1;
        if (!aborted) chk("mem_respack", 64'(mem_if.respack), 64'd1);
      end else if (stray_req != stray_done) begin
        mem_if.respcyc = 1'b1;
        mem_if.resp = 64'hDEAD_BEEF;
        @(negedge clk);
        mem_if.respcyc = 1'b0;
        mem_if.resp = '0;
        stray_done++;
      end
    end
  end

  task automatic start_req(input logic [63:0] a, input bit rd);
    model_apply(a, rd);
    core_if.respack = 1'b0;
    core_if.reqcyc = 1'b1;
    core_if.req = a;
    core_if.reqtag = mk_tag(rd);
    @(posedge clk);
    #1;
    chk("reqack", 64'(core_if.reqack), 64'd1);
    core_if.reqcyc = 1'b0;
  endtask

  task automatic wait_resp(input string nm, input int lat);
    int n;
    n = 1;
    while (!core_if.respcyc && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    last_resp = core_if.resp;
    chk(nm, 64'(n), 64'(lat));
  endtask

  task automatic end_resp();
    core_if.respack = 1'b1;
    @(posedge clk);
    #1;
    chk("resp_drop", 64'(core_if.respcyc), 64'd0);
    exp_fill = 1'b0;
  endtask

  task automatic txn(input string nm, input logic [63:0] a, input bit rd);
    int lat;
    start_req(a, rd);
    lat = (rd && !exp_hit) ? 2 + LW + 1 + ack_delay : 2;
    wait_resp(nm, lat);
    end_resp();
  endtask

  initial begin
    int n;
    core_if.reqcyc = 1'b0;
    core_if.req = '0;
    core_if.reqtag = '0;
    core_if.respack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    txn("lat_miss_1000", 64'h1000, 1'b1);
    chk("pin_first_fill", last_resp, 64'h11);
`ifdef DCACHE_STATS_EN
    chk("pin_miss_count", 64'(miss_count), 64'd1);
`endif

    stray_req++;
    repeat (3) @(posedge clk);
    #1;

    txn("lat_hit_1008", 64'h1008, 1'b1);
    chk("pin_hit_1008", last_resp, 64'h12);
    txn("lat_hit_1000", 64'h1000, 1'b1);
    chk("pin_hit_1000", last_resp, 64'h11);
    txn("lat_conflict", 64'h1000 + SETS * LINE_B, 1'b1);
    chk("pin_conflict", last_resp, 64'h4011);
    txn("lat_refill", 64'h1000, 1'b1);
    chk("pin_refill", last_resp, 64'h11);
    txn("lat_wr_1000", 64'h1000, 1'b0);
    chk("pin_wr_zero", last_resp, 64'h0);
    txn("lat_miss_after_wr", 64'h1000, 1'b1);
    txn("lat_wr_other", 64'h3000, 1'b0);
    txn("lat_hit_kept", 64'h1000, 1'b1);

    // Stalled consumer with a pending request on the bus.
    start_req(64'h1010, 1'b1);
    wait_resp("lat_hit_1010", 2);
    chk("pin_hit_1010", last_resp, 64'h13);
    core_if.reqcyc = 1'b1;
    core_if.req = 64'h1018;
    core_if.reqtag = mk_tag(1'b1);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("busy_no_ack", 64'(core_if.reqack), 64'd0);
      chk("busy_respcyc", 64'(core_if.respcyc), 64'd1);
    end
    core_if.respack = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_gap_resp", 64'(core_if.respcyc), 64'd0);
    chk("idle_gap_ack", 64'(core_if.reqack), 64'd0);
    exp_fill = 1'b0;
    model_apply(64'h1018, 1'b1);
    @(posedge clk);
    #1;
    chk("late_ack", 64'(core_if.reqack), 64'd1);
    core_if.reqcyc = 1'b0;
    core_if.respack = 1'b0;
    wait_resp("lat_hit_1018", 2);
    chk("pin_hit_1018", last_resp, 64'h14);
    end_resp();

    // Reset in the middle of a fill.
    txn("lat_wr_1000_b", 64'h1000, 1'b0);
    start_req(64'h1000, 1'b1);
    n = 0;
    while (beat_idx != 3 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("beat3_reached", 64'(beat_idx), 64'd3);
    #1 reset = 1'b1;
    #1 chk_zero();
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    txn("lat_reread_rst", 64'h1000, 1'b1);
    chk("pin_reread_rst", last_resp, 64'h11);

    ack_delay = 3;
    txn("lat_slow_ack", 64'h1040, 1'b1);
    chk("pin_slow_ack", last_resp, 64'h111);
    ack_delay = 0;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
